// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state encoding, opcode/funct constants and control codes for mc_controller
// MC_ADDI_EN adds the ADDIEX/ADDIWB states.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
`ifdef MC_ADDI_EN
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
`endif
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - unified memory handshake between mc_controller and the memory
interface mc_mem_if;
  logic mem_req;
  logic iord;
  logic memwrite;
  logic mem_ready;

  modport master (output mem_req, iord, memwrite, input mem_ready);
  modport slave  (input mem_req, iord, memwrite, output mem_ready);
endinterface

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - R-type funct to alucontrol mapping; valid=0 flags an unsupported funct
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       valid
);

  always_comb begin
    alucontrol = ALU_ADD;
    valid      = 1'b1;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS-subset control FSM with memory wait timeout
// MC_ADDI_EN enables addi decode (ADDIEX/ADDIWB); otherwise op 001000 is illegal.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  mc_mem_if.master        mem,
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  input  logic            zero,
  output logic            ir_we,
  output logic            pc_we,
  output logic            regwrite,
  output logic            regdst,
  output logic            memtoreg,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsrc,
  output logic [2:0]      alucontrol,
  output logic [3:0]      state_dbg,
  output logic            illegal,
  output logic            mem_err
);

  localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  state_t     dec_nx;
  logic [7:0] wait_cnt;
  logic       mem_err_q;
  logic [2:0] rtype_alu;
  logic       rtype_ok;
  logic       waiting;

  alu_decoder u_alu_dec (
    .funct      (funct),
    .alucontrol (rtype_alu),
    .valid      (rtype_ok)
  );

  // A memory state without mem_ready is a wait cycle; mem_ready always beats the timeout.
  assign waiting = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR))
                   && !mem.mem_ready;

  always_comb begin
    dec_nx = S_FETCH;
    case (op)
      OP_RTYPE: if (rtype_ok) dec_nx = S_EXEC;
      OP_LW,
      OP_SW:    dec_nx = S_MEMADR;
      OP_BEQ:   dec_nx = S_BRANCH;
`ifdef MC_ADDI_EN
      OP_ADDI:  dec_nx = S_ADDIEX;
`endif
      OP_J:     dec_nx = S_JUMP;
      default:  dec_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else if (waiting) begin
      if (wait_cnt == LAST_WAIT) begin
        state     <= S_HALT;
        mem_err_q <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end else begin
      // Counter idles at zero outside wait cycles, so every memory state is entered with it clear.
      wait_cnt <= '0;
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= dec_nx;
        S_MEMADR: state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state <= S_MEMWB;
        S_MEMWR:  state <= S_FETCH;
        S_EXEC:   state <= S_ALUWB;
`ifdef MC_ADDI_EN
        S_ADDIEX: state <= S_ADDIWB;
        S_ADDIWB: state <= S_FETCH;
`endif
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem.mem_req  = 1'b0;
    mem.iord     = 1'b0;
    mem.memwrite = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    regwrite     = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_REG;
    pcsrc        = PC_ALU;
    alucontrol   = ALU_AND;
    state_dbg    = 4'd0;
    illegal      = 1'b0;
    mem_err      = 1'b0;
    // Holding reset low gates every output, including the FETCH memory request.
    if (rst) begin
      state_dbg = state;
      mem_err   = mem_err_q;
      case (state)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          alusrcb     = SRCB_FOUR;
          alucontrol  = ALU_ADD;
          ir_we       = mem.mem_ready;
          pc_we       = mem.mem_ready;
        end
        S_DECODE: begin
          alusrcb    = SRCB_IMMSH;
          alucontrol = ALU_ADD;
          illegal    = (dec_nx == S_FETCH);
        end
        S_MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = SRCB_IMM;
          alucontrol = ALU_ADD;
        end
        S_MEMRD: begin
          mem.mem_req = 1'b1;
          mem.iord    = 1'b1;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_MEMWR: begin
          mem.mem_req  = 1'b1;
          mem.iord     = 1'b1;
          mem.memwrite = 1'b1;
        end
        S_EXEC: begin
          alusrca    = 1'b1;
          alucontrol = rtype_alu;
        end
        S_ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_BRANCH: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          pcsrc      = PC_ALUOUT;
          pc_we      = zero;
        end
`ifdef MC_ADDI_EN
        S_ADDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = SRCB_IMM;
          alucontrol = ALU_ADD;
        end
        S_ADDIWB: regwrite = 1'b1;
`endif
        S_JUMP: begin
          pcsrc = PC_JUMP;
          pc_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller (MEM_TIMEOUT=4); MC_ADDI_EN selects the addi vectors
module tb_mc_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       mreq, iord, mw, irwe, pcwe, rw, rd, m2r, asa;
    logic [1:0] asb, pcs;
    logic [2:0] alu;
    logic       ill, err;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero;
  logic       ir_we, pc_we, regwrite, regdst, memtoreg, alusrca, illegal, mem_err;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_dbg;

  mc_mem_if mem ();

  mc_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem(mem), .op(op), .funct(funct), .zero(zero),
    .ir_we(ir_we), .pc_we(pc_we), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .state_dbg(state_dbg), .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  obs_t  act;
  assign act = {state_dbg, mem.mem_req, mem.iord, mem.memwrite, ir_we, pc_we, regwrite,
                regdst, memtoreg, alusrca, alusrcb, pcsrc, alucontrol, illegal, mem_err};

  obs_t  expq[$];
  string nameq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic obs_t mk(input int st, input bit mreq, iord, mw, irwe, pcwe, rw, rd, m2r, asa,
                              input logic [1:0] asb, pcs, input logic [2:0] alu, input bit ill, err);
    obs_t o;
    o = {st[3:0], mreq, iord, mw, irwe, pcwe, rw, rd, m2r, asa, asb, pcs, alu, ill, err};
    return o;
  endfunction

  task automatic step(input bit rdy, input obs_t e, input string nm);
    mem.mem_ready = rdy;
    expq.push_back(e);
    nameq.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin : monitor
    obs_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e  = expq.pop_front();
        nm = nameq.pop_front();
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, e, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin : stim
    obs_t z, fw, fg, dec, deci, madr, mrd, mwb, mwr, aluwb, br0, br1, jmp, haltv;
    logic [5:0] fn_tab [5];
    logic [2:0] alu_tab[5];
    //        st mrq io mw ir pc rw rd mr as  asb    pcs    alu    il er
    z     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
    fw    = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0);
    fg    = mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0);
    dec   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0, 0);
    deci  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 1, 0);
    madr  = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0);
    mrd   = mk(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
    mwb   = mk(4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0, 0);
    mwr   = mk(5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
    aluwb = mk(7, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
    br0   = mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0, 0);
    br1   = mk(8, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0, 0);
    jmp   = mk(11,0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0, 0);
    haltv = mk(12,0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 1);
    fn_tab  = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010};
    alu_tab = '{3'b110,    3'b010,    3'b000,    3'b001,    3'b111};

    rst = 1'b0; op = '0; funct = '0; zero = 1'b0; mem.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(1, z, "reset_gated_ready1");
    step(0, z, "reset_gated_ready0");
    rst = 1'b1;

    // R-type: sub first, then add/and/or/slt
    for (int i = 0; i < 5; i++) begin
      op = 6'b000000; funct = fn_tab[i];
      step(1, fg, "rtype_fetch");
      step(1, dec, "rtype_decode");
      step(1, mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, alu_tab[i], 0, 0), "rtype_exec");
      step(1, aluwb, "rtype_aluwb");
    end

    // lw with mem_ready low 3 cycles; ready on the 4th wins over the timeout
    op = 6'b100011;
    step(1, fg, "lw_fetch");
    step(1, dec, "lw_decode");
    step(1, madr, "lw_memadr");
    step(0, mrd, "lw_memrd_wait1");
    step(0, mrd, "lw_memrd_wait2");
    step(0, mrd, "lw_memrd_wait3");
    step(1, mrd, "lw_memrd_ready");
    step(1, mwb, "lw_memwb");

    // sw with two fetch wait cycles
    op = 6'b101011;
    step(0, fw, "sw_fetch_wait1");
    step(0, fw, "sw_fetch_wait2");
    step(1, fg, "sw_fetch");
    step(1, dec, "sw_decode");
    step(1, madr, "sw_memadr");
    step(1, mwr, "sw_memwr");

    op = 6'b000100; zero = 1'b0;
    step(1, fg, "beq0_fetch");
    step(1, dec, "beq0_decode");
    step(1, br0, "beq0_branch");
    zero = 1'b1;
    step(1, fg, "beq1_fetch");
    step(1, dec, "beq1_decode");
    step(1, br1, "beq1_branch");
    zero = 1'b0;

    op = 6'b000010;
    step(1, fg, "j_fetch");
    step(1, dec, "j_decode");
    step(1, jmp, "j_jump");

    op = 6'b111111;
    step(1, fg, "badop_fetch");
    step(1, deci, "badop_decode");

    op = 6'b000000; funct = 6'b000000;
    step(1, fg, "badfunct_fetch");
    step(1, deci, "badfunct_decode");

    op = 6'b001000;
    step(1, fg, "addi_fetch");
`ifdef MC_ADDI_EN
    step(1, dec, "addi_decode");
    step(1, mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0), "addi_exec");
    step(1, mk(10,0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0), "addi_wb");
`else
    step(1, deci, "addi_illegal");
`endif

    // reset asserted while MEMWR is waiting
    op = 6'b101011;
    step(1, fg, "swrst_fetch");
    step(1, dec, "swrst_decode");
    step(1, madr, "swrst_memadr");
    step(0, mwr, "swrst_memwr_wait");
    rst = 1'b0;
    step(0, z, "swrst_reset_drop");
    rst = 1'b1;
    op = 6'b000010;
    step(1, fg, "post_reset_fetch");
    step(1, dec, "post_reset_decode");
    step(1, jmp, "post_reset_jump");

    // fetch timeout: 4 wait cycles then HALT, which only reset leaves
    step(0, fw, "to_fetch_wait1");
    step(0, fw, "to_fetch_wait2");
    step(0, fw, "to_fetch_wait3");
    step(0, fw, "to_fetch_wait4");
    step(0, haltv, "halt_1");
    step(1, haltv, "halt_ready_ignored");
    step(1, haltv, "halt_3");
    rst = 1'b0;
    step(1, z, "halt_reset");
    rst = 1'b1;
    step(0, fw, "post_halt_fetch");

    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: actual=%0d left required=0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, giving the maximum wait cycles for mem_ready before error (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous active-low.
REQ-004 SHALL have port op, input, 6, instruction register bits [31:26].
REQ-005 SHALL have port funct, input, 6, instruction register bits [5:0].
REQ-006 SHALL have port zero, input, 1, ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1, unified memory acknowledge.
REQ-008 SHALL have ports mem_req, iord, memwrite, ir_we, pc_we, regwrite, regdst, memtoreg, alusrca, each output, 1.
REQ-009 SHALL have ports alusrcb (output, 2: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2) and pcsrc (output, 2: 00 ALU result, 01 ALUOut, 10 jump target).
REQ-010 SHALL have ports alucontrol (output, 3), state_dbg (output, 4), illegal (output, 1), mem_err (output, 1).

Function
REQ-011 SHALL be a Moore FSM: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT; state_dbg = encoding.
REQ-012 FETCH SHALL drive mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00; ir_we=pc_we=1 only in the cycle mem_ready=1, then go to DECODE; otherwise stay.
REQ-013 DECODE SHALL drive alusrcb=11, alucontrol=010 and branch on op: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP.
REQ-014 Unsupported op, or R-type with funct outside {100000,100010,100100,100101,101010}, SHALL pulse illegal for one cycle in DECODE and go to FETCH with no write.
REQ-015 MEMADR SHALL drive alusrca=1, alusrcb=10, alucontrol=010, then MEMRD (lw) or MEMWR (sw).
REQ-016 MEMRD SHALL drive mem_req=1, iord=1, waiting for mem_ready, then MEMWB (regwrite=1, memtoreg=1, regdst=0) -> FETCH.
REQ-017 MEMWR SHALL drive mem_req=1, iord=1, memwrite=1 until mem_ready, then FETCH.
REQ-018 EXEC SHALL drive alusrca=1, alusrcb=00, alucontrol from funct (add 010, sub 110, and 000, or 001, slt 111); ALUWB SHALL drive regwrite=1, regdst=1, memtoreg=0 -> FETCH.
REQ-019 BRANCH SHALL drive alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pc_we=zero -> FETCH.
REQ-020 JUMP SHALL drive pcsrc=10, pc_we=1 -> FETCH; ADDIEX SHALL drive alusrca=1, alusrcb=10, alucontrol=010 -> ADDIWB (regwrite=1, regdst=0) -> FETCH.
REQ-021 Latency with mem_ready held 1 SHALL be: beq/j 3, R-type/addi/sw 4, lw 5 cycles.
REQ-022 An 8-bit wait counter SHALL clear on entry to each memory state and increment per cycle of mem_req=1 without mem_ready; reaching MEM_TIMEOUT SHALL enter HALT and set mem_err.
REQ-023 HALT SHALL drive all enables 0, hold mem_err=1, and exit only by reset.
REQ-024 mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL win: transfer completes, no error.
REQ-025 Outputs not listed for a state SHALL be 0.

Reset
REQ-026 rst=0 SHALL asynchronously force state=FETCH, counter=0, mem_err=0, and gate every output to 0 while low.
REQ-027 Reset mid-transaction SHALL drop mem_req/memwrite immediately; first cycle after release SHALL be FETCH.

Configuration
REQ-028 With MC_ADDI_EN defined, op 001000 SHALL decode to ADDIEX; without it, ADDIEX/ADDIWB SHALL not exist and op 001000 SHALL be illegal.

Structure
REQ-029 Package mc_ctrl_pkg SHALL hold state encoding, opcode/funct constants, alucontrol and alusrcb/pcsrc codes.
REQ-030 Funct-to-alucontrol mapping SHALL be sub-module alu_decoder.

Verification
REQ-031 op=000000, funct=100010, mem_ready=1 -> FETCH, DECODE, EXEC (alucontrol=110), ALUWB (regwrite=1, regdst=1), FETCH.
REQ-032 lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with memtoreg=1; total 8 cycles.
REQ-033 beq zero=0 -> pc_we=0 in BRANCH; zero=1 -> pc_we=1, pcsrc=01.
REQ-034 MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> HALT after 4 cycles, mem_err=1 until rst=0.
REQ-035 op=111111 -> illegal=1 one cycle, no regwrite/memwrite, back to FETCH; op=001000 without MC_ADDI_EN -> illegal=1.
REQ-036 rst=0 asserted during MEMWR -> memwrite=0 same cycle; after release state_dbg=FETCH.
